// File: rtl/run_one_readout.sv
// ============================================================================
//  Module      : run_one_readout
//  Description : Captures per-lane run/ones counts and the sample total in one
//                cycle, then streams them as a 32-bit valid/ready frame.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module run_one_readout #(
    parameter int          N_STREAMS = 32,
    parameter logic [15:0] MAGIC     = 16'hA55A
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [63:0]         run_count [N_STREAMS-1:0],
    input  logic [63:0]         one_count [N_STREAMS-1:0],
    input  logic [63:0]         total,
    output logic [31:0]         m_data,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_cnt
);

    localparam int                 c_NWORDS   = 3 + 4 * N_STREAMS;
    localparam int                 c_IDX_W    = $clog2(c_NWORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NWORDS - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [63:0]        r_total;
    logic [63:0]        r_run [N_STREAMS-1:0];
    logic [63:0]        r_one [N_STREAMS-1:0];
    logic               r_done;
    logic [15:0]        r_frame_cnt;
    logic [31:0]        w_word;
    logic               w_send;
    logic               w_at_last;

    assign w_send    = (r_state == c_ST_SEND);
    assign w_at_last = (r_idx == c_LAST_IDX);

    assign m_valid   = w_send;
    assign busy      = w_send;
    assign m_last    = w_send && w_at_last;
    assign m_data    = w_send ? w_word : 32'h0;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

    // Word selection: 3 header words, then 4 words per lane (run lo/hi, ones lo/hi).
    always_comb begin
        w_word = 32'h0;
        if (r_idx == c_IDX_W'(0)) w_word = {MAGIC, 16'(N_STREAMS)};
        if (r_idx == c_IDX_W'(1)) w_word = r_total[31:0];
        if (r_idx == c_IDX_W'(2)) w_word = r_total[63:32];
        for (int s = 0; s < N_STREAMS; s++) begin
            if (r_idx == c_IDX_W'(3 + 4 * s)) w_word = r_run[s][31:0];
            if (r_idx == c_IDX_W'(4 + 4 * s)) w_word = r_run[s][63:32];
            if (r_idx == c_IDX_W'(5 + 4 * s)) w_word = r_one[s][31:0];
            if (r_idx == c_IDX_W'(6 + 4 * s)) w_word = r_one[s][63:32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_total     <= '0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            for (int s = 0; s < N_STREAMS; s++) begin
                r_run[s] <= '0;
                r_one[s] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_total <= total;
                        for (int s = 0; s < N_STREAMS; s++) begin
                            r_run[s] <= run_count[s];
                            r_one[s] <= one_count[s];
                        end
                        r_idx   <= '0;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (m_ready) begin
                        if (w_at_last) begin
                            r_idx       <= '0;
                            r_state     <= c_ST_IDLE;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_run_one_readout.sv
// ============================================================================
//  Module      : tb_run_one_readout
//  Description : Scoreboard bench for run_one_readout; expected frames are
//                queued at start and checked by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_run_one_readout;

    localparam int c_N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] run_count [c_N-1:0];
    logic [63:0] one_count [c_N-1:0];
    logic [63:0] total;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    bit   scramble = 0;
    bit   rdy_rand = 0;

    run_one_readout #(.N_STREAMS(c_N), .MAGIC(16'hA55A)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .run_count (run_count),
        .one_count (one_count),
        .total     (total),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pattern 0 is the reference frame; pattern 1 uses distinct per-lane values.
    function automatic logic [63:0] pat_run(input int p, input int s);
        if (p == 0) return 64'h0000_0001_0000_0000 + 64'(s);
        return {32'h1000_0000 + 32'(s), 32'h8000_0000 | (32'(s) << 8)};
    endfunction

    function automatic logic [63:0] pat_one(input int p, input int s);
        if (p == 0) return 64'hFFFF_0000_0000_0000 | 64'(s);
        return {32'h0BAD_0000 | 32'(s), 32'h0000_F000 + 32'(s)};
    endfunction

    function automatic logic [63:0] pat_tot(input int p);
        if (p == 0) return 64'h0000_0002_0000_0003;
        return 64'h1234_5678_9ABC_DEF0;
    endfunction

    task automatic apply(input int p);
        for (int s = 0; s < c_N; s++) begin
            run_count[s] = pat_run(p, s);
            one_count[s] = pat_one(p, s);
        end
        total = pat_tot(p);
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int p);
        logic [63:0] t;
        logic [63:0] r;
        logic [63:0] o;
        t = pat_tot(p);
        push(32'hA55A0020, 1'b0);
        push(t[31:0], 1'b0);
        push(t[63:32], 1'b0);
        for (int s = 0; s < c_N; s++) begin
            r = pat_run(p, s);
            o = pat_one(p, s);
            push(r[31:0], 1'b0);
            push(r[63:32], 1'b0);
            push(o[31:0], 1'b0);
            push(o[63:32], s == c_N - 1);
        end
    endtask

    // Call just after a posedge (or in the cycle start should be sampled).
    task automatic start_frame(input int p);
        apply(p);
        start = 1'b1;
        n_pop = 0;
        push_frame(p);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("latency_valid", {63'b0, m_valid}, 64'd1);
        check("latency_busy", {63'b0, busy}, 64'd1);
        check("latency_header", {32'b0, m_data}, 64'hA55A0020);
    endtask

    task automatic wait_end(input logic [15:0] exp_fc, input int exp_vc);
        int vc = 0;
        int t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            if (m_valid) vc++;
            t++;
        end
        check("frame_end_timeout", {63'b0, done}, 64'd1);
        check("end_valid", {63'b0, m_valid}, 64'd0);
        check("end_busy", {63'b0, busy}, 64'd0);
        check("end_last", {63'b0, m_last}, 64'd0);
        check("end_frame_cnt", {48'b0, frame_cnt}, {48'b0, exp_fc});
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        if (exp_vc >= 0) check("valid_cycles", 64'(vc), 64'(exp_vc));
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (n_pop < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("wait_pops_timeout", {63'b0, n_pop >= n}, 64'd1);
    endtask

    // Monitor: compares every accepted word and checks stability during stalls.
    logic        stalled = 1'b0;
    logic [31:0] held_d;
    logic        held_l;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", {63'b0, m_valid}, 64'd1);
                check("stall_data", {32'b0, m_data}, {32'b0, held_d});
                check("stall_last", {63'b0, m_last}, {63'b0, held_l});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {32'b0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("word%0d_data", n_pop), {32'b0, m_data}, {32'b0, e.d});
                    check($sformatf("word%0d_last", n_pop), {63'b0, m_last}, {63'b0, e.l});
                end
                n_pop++;
            end
            stalled = m_valid && !m_ready;
            held_d  = m_data;
            held_l  = m_last;
        end
    end

    always @(posedge clk) begin
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (scramble) begin
            for (int s = 0; s < c_N; s++) begin
                run_count[s] = {$urandom, $urandom};
                one_count[s] = {$urandom, $urandom};
            end
            total = {$urandom, $urandom};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
        apply(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {63'b0, m_valid}, 64'd0);
        check("rst_last", {63'b0, m_last}, 64'd0);
        check("rst_data", {32'b0, m_data}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_frame_cnt", {48'b0, frame_cnt}, 64'd0);
        rst = 1'b0;

        // Idle with no start
        repeat (10) begin
            @(negedge clk);
            check("idle_valid", {63'b0, m_valid}, 64'd0);
            check("idle_busy", {63'b0, busy}, 64'd0);
        end
        check("idle_frame_cnt", {48'b0, frame_cnt}, 64'd0);

        // Full reference frame, no backpressure
        @(posedge clk); #1;
        start_frame(0);
        wait_end(16'd1, 131);
        @(negedge clk);
        check("done_one_cycle", {63'b0, done}, 64'd0);

        // Snapshot isolation: inputs scrambled every cycle after capture
        @(posedge clk); #1;
        start_frame(1);
        scramble = 1;
        wait_end(16'd2, 131);
        scramble = 0;

        // Random backpressure
        rdy_rand = 1;
        @(posedge clk); #1;
        start_frame(0);
        wait_end(16'd3, -1);
        rdy_rand = 0;
        @(negedge clk);
        check("bp_done_one_cycle", {63'b0, done}, 64'd0);

        // Start while busy (mid-frame and on the last handshake), then back-to-back
        @(posedge clk); #1;
        start_frame(1);
        wait_pops(40);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int t = 0;
            while (!(m_valid && m_last) && t < 500) begin
                @(negedge clk);
                t++;
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(16'd4, -1);
        start_frame(0);
        wait_end(16'd5, 131);

        // Reset mid-frame
        @(posedge clk); #1;
        start_frame(1);
        wait_pops(77);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid", {63'b0, m_valid}, 64'd0);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_data", {32'b0, m_data}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_frame_cnt", {48'b0, frame_cnt}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start_frame(0);
        wait_end(16'd1, 131);
        @(negedge clk);
        check("final_done_low", {63'b0, done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
